// File: rtl/spi_clkgen_pkg.sv
// spi_clkgen_pkg: shared types and constants for the SPI SCLK generator.
//   state_t     : burst FSM states (IDLE, RUN)
//   CNT_W_DEF   : default width of the half-period divisor / prescale counter
//   NCYC_W_DEF  : default width of the burst length
//   SCLK_RST    : SCLK level while reset is asserted
package spi_clkgen_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  localparam int   CNT_W_DEF  = 16;
  localparam int   NCYC_W_DEF = 8;
  localparam logic SCLK_RST   = 1'b0;

endpackage

// File: rtl/spi_clkgen_tick.sv
// spi_clkgen_tick: prescale counter for the SCLK generator.
// Counts 0..div_q and wraps, so tc fires once every div_q+1 cycles while
// clear is low. clear holds the count at zero and suppresses tc.
// Ports:
//   CLK, RST : clock, asynchronous active-high reset
//   clear    : hold counter at zero (idle / abort)
//   div_q    : latched half-period minus one
//   tc       : terminal count, high in the cycle before SCLK must toggle
module spi_clkgen_tick
  import spi_clkgen_pkg::*;
#(
  parameter int CNT_W = CNT_W_DEF
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             clear,
  input  logic [CNT_W-1:0] div_q,
  output logic             tc
);

  logic [CNT_W-1:0] cnt;
  logic             at_end;

  assign at_end = (cnt == div_q);
  assign tc     = !clear && at_end;

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      cnt <= '0;
    end else if (clear || at_end) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/spi_clk_gen.sv
// spi_clk_gen: runtime-programmable SCLK burst generator for the SPI master.
// On START (in IDLE, without ABORT) latches DIV/NCYC/CPOL and emits NCYC
// SCLK cycles, each half-period DIV+1 CLK cycles, with one-cycle strobes
// on leading (away from CPOL) and trailing (back to CPOL) edges. DONE pulses
// on the last trailing edge; BUSY covers the burst. All outputs registered.
// Optional build macro SPI_CLKGEN_FREE_RUN_EN adds input FREE: when latched
// high the burst ignores NCYC and runs until ABORT, never pulsing DONE.
// Ports:
//   CLK, RST           : clock, asynchronous active-high reset
//   START, ABORT       : burst request / immediate termination (ABORT wins)
//   DIV, NCYC, CPOL    : half-period-1, burst length, idle level
//   FREE               : free-running burst (only with SPI_CLKGEN_FREE_RUN_EN)
//   SCLK               : serial clock
//   LEAD_STB/TRAIL_STB : edge strobes coincident with SCLK changes
//   BUSY, DONE         : burst active / normal completion pulse
module spi_clk_gen
  import spi_clkgen_pkg::*;
#(
  parameter int CNT_W  = CNT_W_DEF,
  parameter int NCYC_W = NCYC_W_DEF
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              START,
  input  logic              ABORT,
  input  logic [CNT_W-1:0]  DIV,
  input  logic [NCYC_W-1:0] NCYC,
  input  logic              CPOL,
`ifdef SPI_CLKGEN_FREE_RUN_EN
  input  logic              FREE,
`endif
  output logic              SCLK,
  output logic              LEAD_STB,
  output logic              TRAIL_STB,
  output logic              BUSY,
  output logic              DONE
);

  state_t            state, state_n;
  logic [CNT_W-1:0]  div_q;
  logic [NCYC_W-1:0] ncyc_q;
  logic [NCYC_W-1:0] edge_cnt, edge_n, edge_inc;
  logic              cpol_q, cpol_n;
  logic              sclk_q, sclk_n;
  logic              lead_q, lead_n;
  logic              trail_q, trail_n;
  logic              busy_q, busy_n;
  logic              done_q, done_n;
  logic              latch;
  logic              tick_clear;
  logic              tc;
  logic              free_q;
  logic              start_free;

`ifdef SPI_CLKGEN_FREE_RUN_EN
  assign start_free = FREE;

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      free_q <= 1'b0;
    end else if (latch) begin
      free_q <= FREE;
    end
  end
`else
  assign start_free = 1'b0;
  assign free_q     = 1'b0;
`endif

  // Counter only runs in RUN; abort clears it on the same edge as the FSM.
  assign tick_clear = (state == IDLE) || ABORT;

  spi_clkgen_tick #(
    .CNT_W (CNT_W)
  ) u_tick (
    .CLK   (CLK),
    .RST   (RST),
    .clear (tick_clear),
    .div_q (div_q),
    .tc    (tc)
  );

  // edge_cnt < ncyc_q throughout RUN, so the increment cannot wrap.
  assign edge_inc = edge_cnt + 1'b1;

  always_comb begin
    state_n = state;
    sclk_n  = sclk_q;
    lead_n  = 1'b0;
    trail_n = 1'b0;
    busy_n  = busy_q;
    done_n  = 1'b0;
    edge_n  = edge_cnt;
    cpol_n  = cpol_q;
    latch   = 1'b0;
    case (state)
      IDLE: begin
        sclk_n = cpol_q;
        if (START && !ABORT) begin
          // A zero-length burst completes at once without touching SCLK.
          if ((NCYC == '0) && !start_free) begin
            done_n = 1'b1;
          end else begin
            latch   = 1'b1;
            cpol_n  = CPOL;
            sclk_n  = CPOL;
            busy_n  = 1'b1;
            edge_n  = '0;
            state_n = RUN;
          end
        end
      end
      RUN: begin
        if (ABORT) begin
          state_n = IDLE;
          busy_n  = 1'b0;
          sclk_n  = cpol_q;
          edge_n  = '0;
        end else if (tc) begin
          sclk_n = ~sclk_q;
          if (sclk_q == cpol_q) begin
            lead_n = 1'b1;
          end else begin
            trail_n = 1'b1;
            if (!free_q) begin
              edge_n = edge_inc;
              if (edge_inc == ncyc_q) begin
                state_n = IDLE;
                busy_n  = 1'b0;
                done_n  = 1'b1;
              end
            end
          end
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state    <= IDLE;
      sclk_q   <= SCLK_RST;
      lead_q   <= 1'b0;
      trail_q  <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      edge_cnt <= '0;
      cpol_q   <= 1'b0;
    end else begin
      state    <= state_n;
      sclk_q   <= sclk_n;
      lead_q   <= lead_n;
      trail_q  <= trail_n;
      busy_q   <= busy_n;
      done_q   <= done_n;
      edge_cnt <= edge_n;
      cpol_q   <= cpol_n;
    end
  end

  // Burst parameters are data: only meaningful once latched, so no reset.
  always_ff @(posedge CLK) begin
    if (latch) begin
      div_q  <= DIV;
      ncyc_q <= NCYC;
    end
  end

  assign SCLK      = sclk_q;
  assign LEAD_STB  = lead_q;
  assign TRAIL_STB = trail_q;
  assign BUSY      = busy_q;
  assign DONE      = done_q;

endmodule
